pipe_sample_capture: RTL and testbench

- Downstream of the 12-FIFO pipeline block: consumes one group's registered 192-bit pipeline output word (16 ch x 12 bit) every RDCLK.
- On an L1A match, captures NSAMP consecutive words into a local event buffer with last-word markers.
- Readout logic pulls complete events with a pop handshake. One instance per group (six per board).

---
 rtl/pipe_sample_capture_pkg.sv | 12 +
 rtl/pipe_evt_ram.sv | 31 +++
 rtl/pipe_sample_capture.sv | 157 +++++++++++++++
 tb/tb_pipe_sample_capture.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_sample_capture_pkg.sv
// Shared pipeline/DAQ constants and capture FSM encoding for the per-group
// sample capture block.
package pipe_sample_capture_pkg;
  localparam int unsigned PIPE_DW = 192;
  localparam int unsigned NSAMP_W = 7;
  localparam int unsigned OVFL_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    CAPT = 1'b1
  } capt_state_t;
endpackage

// File: rtl/pipe_evt_ram.sv
// Simple dual-port event buffer: one write port, one registered read port,
// single clock. The data array itself is never reset.
module pipe_evt_ram
  import pipe_sample_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned W     = PIPE_DW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pipe_sample_capture.sv
// Captures NSAMP consecutive pipeline words per accepted L1A into a local
// event buffer and hands complete events to readout through a pop handshake.
module pipe_sample_capture
  import pipe_sample_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = PIPE_DW
) (
  input  logic               RDCLK,
  input  logic               RST_N,
  input  logic               FLUSH,
  input  logic               L1A_MATCH,
  input  logic [NSAMP_W-1:0] NSAMP,
  input  logic [DW-1:0]      PIPOUT,
  input  logic               RD_EN,
  output logic [DW-1:0]      DOUT,
  output logic               DOUT_VLD,
  output logic               DOUT_LAST,
  output logic               DATA_AVAIL,
  output logic [AW:0]        EVT_CNT,
  output logic [AW:0]        WORDS_USED,
  output logic [OVFL_W-1:0]  OVFL_CNT,
  output logic               BUSY
);

  capt_state_t        state;
  logic [NSAMP_W-1:0] len, idx;
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [DEPTH-1:0]   last_flag;
  logic [AW:0]        free;
  logic               last_capt, start, drop, wr_en, wr_last, pop, pop_last;
  logic [DW:0]        ram_q;

  always_comb begin
    free      = (AW+1)'(DEPTH) - WORDS_USED;
    last_capt = (state == CAPT) && (idx == len - NSAMP_W'(1));
    start     = 1'b0;
    drop      = 1'b0;
    wr_en     = 1'b0;
    wr_last   = 1'b0;
    if (!FLUSH) begin
      if (state == IDLE) begin
        if (L1A_MATCH && NSAMP != '0) begin
          if (free >= (AW+1)'(NSAMP)) begin
            start   = 1'b1;
            wr_en   = 1'b1;
            wr_last = (NSAMP == NSAMP_W'(1));
          end else begin
            drop = 1'b1;
          end
        end
      end else begin
        wr_en   = 1'b1;
        wr_last = last_capt;
        if (L1A_MATCH) begin
          if (!last_capt) drop = 1'b1;
          else if (NSAMP != '0) begin
            if (free - (AW+1)'(1) >= (AW+1)'(NSAMP)) start = 1'b1;
            else                                     drop  = 1'b1;
          end
        end
      end
    end
    pop      = !FLUSH && RD_EN && (EVT_CNT != '0);
    pop_last = last_flag[rd_ptr];
  end

  // An L1A accepted on the final CAPT cycle cannot share that cycle's write
  // slot, so the new event starts on the next cycle (idx restarts at 0).
  always_ff @(posedge RDCLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      len   <= '0;
      idx   <= '0;
      BUSY  <= 1'b0;
    end else if (FLUSH) begin
      state <= IDLE;
      idx   <= '0;
      BUSY  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start && NSAMP != NSAMP_W'(1)) begin
          state <= CAPT;
          len   <= NSAMP;
          idx   <= NSAMP_W'(1);
          BUSY  <= 1'b1;
        end
        CAPT: if (last_capt) begin
          if (start) begin
            len <= NSAMP;
            idx <= '0;
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end else begin
          idx <= idx + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge RDCLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      WORDS_USED <= '0;
      EVT_CNT    <= '0;
      DATA_AVAIL <= 1'b0;
      DOUT_VLD   <= 1'b0;
      OVFL_CNT   <= '0;
    end else begin
      DOUT_VLD <= pop;
      if (drop && OVFL_CNT != '1) OVFL_CNT <= OVFL_CNT + 1'b1;
      if (FLUSH) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        WORDS_USED <= '0;
        EVT_CNT    <= '0;
        DATA_AVAIL <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + 1'b1;
        if (pop)   rd_ptr <= rd_ptr + 1'b1;
        WORDS_USED <= WORDS_USED + (AW+1)'(wr_en) - (AW+1)'(pop);
        EVT_CNT    <= EVT_CNT + (AW+1)'(wr_en && wr_last) - (AW+1)'(pop && pop_last);
        DATA_AVAIL <= (EVT_CNT + (AW+1)'(wr_en && wr_last) - (AW+1)'(pop && pop_last)) != '0;
      end
    end
  end

  // Shadow copy of the last markers so a pop can retire an event in the
  // same cycle, before the RAM read data is available.
  always_ff @(posedge RDCLK) begin
    if (wr_en) last_flag[wr_ptr] <= wr_last;
  end

  pipe_evt_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (DW + 1)
  ) u_ram (
    .clk   (RDCLK),
    .rst_n (RST_N),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({wr_last, PIPOUT}),
    .re    (pop),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  assign DOUT      = ram_q[DW-1:0];
  assign DOUT_LAST = ram_q[DW];

endmodule

// File: tb/tb_pipe_sample_capture.sv
// Bench for pipe_sample_capture: queue-level event buffer model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_pipe_sample_capture;
  localparam int DEPTH = 256;
  localparam int DW    = 192;

  logic          RDCLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          FLUSH = 1'b0;
  logic          L1A_MATCH = 1'b0;
  logic [6:0]    NSAMP = '0;
  logic [DW-1:0] PIPOUT = '0;
  logic          RD_EN = 1'b0;
  logic [DW-1:0] DOUT;
  logic          DOUT_VLD, DOUT_LAST, DATA_AVAIL, BUSY;
  logic [8:0]    EVT_CNT, WORDS_USED;
  logic [7:0]    OVFL_CNT;

  pipe_sample_capture #(.DEPTH(DEPTH), .AW(8), .DW(DW)) dut (
    .RDCLK(RDCLK), .RST_N(RST_N), .FLUSH(FLUSH), .L1A_MATCH(L1A_MATCH),
    .NSAMP(NSAMP), .PIPOUT(PIPOUT), .RD_EN(RD_EN), .DOUT(DOUT),
    .DOUT_VLD(DOUT_VLD), .DOUT_LAST(DOUT_LAST), .DATA_AVAIL(DATA_AVAIL),
    .EVT_CNT(EVT_CNT), .WORDS_USED(WORDS_USED), .OVFL_CNT(OVFL_CNT), .BUSY(BUSY)
  );

  always #5 RDCLK = ~RDCLK;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;
  bit rnd = 0;

  // model: buffer contents as a queue of {last, data}, words left to write
  logic [DW:0] mq[$];
  int          remaining;
  int          m_evt;
  int          m_ovfl;
  bit          m_vld;
  logic [DW:0] m_dout;

  task automatic chk(input string nm, input logic [199:0] got, input logic [199:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    remaining = 0;
    m_evt = 0;
    m_ovfl = 0;
    m_vld = 0;
    m_dout = '0;
  endtask

  task automatic model_step();
    bit busy, accept;
    int free, add, sub;
    logic [DW:0] w;
    if (!RST_N) begin
      model_reset();
      return;
    end
    if (FLUSH) begin
      mq.delete();
      remaining = 0;
      m_evt = 0;
      m_vld = 0;
      return;
    end
    busy = remaining > 0;
    accept = 0;
    add = 0;
    sub = 0;
    if (L1A_MATCH) begin
      if (busy && remaining > 1) begin
        if (m_ovfl < 255) m_ovfl++;
      end else if (NSAMP != 0) begin
        free = DEPTH - mq.size() - (busy ? 1 : 0);
        if (free >= int'(NSAMP)) accept = 1;
        else if (m_ovfl < 255) m_ovfl++;
      end
    end
    m_vld = 0;
    if (RD_EN && m_evt > 0) begin
      w = mq.pop_front();
      m_vld = 1;
      m_dout = w;
      if (w[DW]) sub = 1;
    end
    if (busy) begin
      mq.push_back({remaining == 1, PIPOUT});
      if (remaining == 1) add = 1;
      remaining--;
    end
    if (accept) begin
      if (!busy) begin
        mq.push_back({NSAMP == 1, PIPOUT});
        if (NSAMP == 1) add = 1;
        remaining = int'(NSAMP) - 1;
      end else begin
        remaining = int'(NSAMP);
      end
    end
    m_evt = m_evt + add - sub;
  endtask

  task automatic step();
    @(posedge RDCLK);
    #1;
    model_step();
    if (rnd) PIPOUT = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    else     PIPOUT = PIPOUT + 1'b1;
  endtask

  task automatic do_reset();
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("rst_used", WORDS_USED, 0);
    chk("rst_evt", EVT_CNT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovfl", OVFL_CNT, 0);
    chk("rst_vld", DOUT_VLD, 0);
    step();
    step();
    RST_N = 1'b1;
  endtask

  always @(negedge RDCLK) begin
    if (chk_on) begin
      chk("vld", DOUT_VLD, m_vld);
      chk("dout", DOUT, m_dout[DW-1:0]);
      chk("dout_last", DOUT_LAST, m_dout[DW]);
      chk("avail", DATA_AVAIL, m_evt != 0);
      chk("evt_cnt", EVT_CNT, m_evt);
      chk("words_used", WORDS_USED, mq.size());
      chk("ovfl_cnt", OVFL_CNT, m_ovfl);
      chk("busy", BUSY, remaining > 0);
    end
  end

  initial begin
    int nlast, first, nv, lastv;
    bit contig;
    logic [DW-1:0] prev;
    model_reset();
    step();
    step();
    RST_N = 1'b1;
    chk_on = 1;
    chk("init_used", WORDS_USED, 0);
    chk("init_evt", EVT_CNT, 0);
    step();

    // single 8-sample event, then read back
    NSAMP = 7'd8;
    PIPOUT = 192'h10;
    L1A_MATCH = 1'b1;
    step();
    L1A_MATCH = 1'b0;
    repeat (7) step();
    chk("t1_evt", EVT_CNT, 1);
    chk("t1_used", WORDS_USED, 8);
    chk("t1_busy", BUSY, 0);
    RD_EN = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("t1_vld", DOUT_VLD, 1);
      chk("t1_dout", DOUT, 32'h10 + k);
      chk("t1_last", DOUT_LAST, k == 7);
    end
    RD_EN = 1'b0;
    chk("t1_evt0", EVT_CNT, 0);
    step();
    chk("t1_vld0", DOUT_VLD, 0);

    // three back-to-back 4-sample events
    NSAMP = 7'd4;
    for (int e = 0; e < 3; e++) begin
      L1A_MATCH = 1'b1;
      step();
      L1A_MATCH = 1'b0;
      repeat (3) step();
    end
    step();
    chk("t2_evt", EVT_CNT, 3);
    chk("t2_used", WORDS_USED, 12);
    chk("t2_ovfl", OVFL_CNT, 0);
    RD_EN = 1'b1;
    nlast = 0;
    contig = 1;
    prev = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (DOUT_LAST) nlast++;
      if (k > 0 && DOUT != prev + 1'b1) contig = 0;
      prev = DOUT;
    end
    RD_EN = 1'b0;
    chk("t2_lasts", nlast, 3);
    chk("t2_contig", contig, 1);

    // L1A two cycles into a capture is dropped
    L1A_MATCH = 1'b1;
    step();
    L1A_MATCH = 1'b0;
    step();
    L1A_MATCH = 1'b1;
    step();
    L1A_MATCH = 1'b0;
    repeat (4) step();
    chk("t3_ovfl", OVFL_CNT, 1);
    chk("t3_evt", EVT_CNT, 1);
    chk("t3_used", WORDS_USED, 4);
    RD_EN = 1'b1;
    repeat (4) step();
    RD_EN = 1'b0;
    step();

    // space exhaustion and OVFL_CNT saturation
    do_reset();
    NSAMP = 7'd100;
    for (int e = 0; e < 3; e++) begin
      L1A_MATCH = 1'b1;
      step();
      L1A_MATCH = 1'b0;
      repeat (119) step();
    end
    chk("t4_ovfl", OVFL_CNT, 1);
    chk("t4_used", WORDS_USED, 200);
    chk("t4_evt", EVT_CNT, 2);
    L1A_MATCH = 1'b1;
    repeat (300) step();
    L1A_MATCH = 1'b0;
    step();
    chk("t4_sat", OVFL_CNT, 255);
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
    chk("t4_fl_used", WORDS_USED, 0);
    chk("t4_fl_ovfl", OVFL_CNT, 255);

    // RD_EN held through a capture: nothing pops until the event completes
    RD_EN = 1'b1;
    NSAMP = 7'd16;
    L1A_MATCH = 1'b1;
    first = -1;
    nv = 0;
    lastv = 0;
    for (int s = 1; s <= 40; s++) begin
      step();
      L1A_MATCH = 1'b0;
      if (DOUT_VLD) begin
        if (first < 0) first = s;
        nv++;
        lastv = s;
      end
    end
    RD_EN = 1'b0;
    chk("t5_first", first, 17);
    chk("t5_count", nv, 16);
    chk("t5_run", lastv - first, 15);
    chk("t5_used", WORDS_USED, 0);

    // FLUSH at sample 5, then async reset mid-capture
    L1A_MATCH = 1'b1;
    step();
    L1A_MATCH = 1'b0;
    repeat (4) step();
    FLUSH = 1'b1;
    L1A_MATCH = 1'b1;
    step();
    FLUSH = 1'b0;
    L1A_MATCH = 1'b0;
    chk("t6_used", WORDS_USED, 0);
    chk("t6_evt", EVT_CNT, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_ovfl", OVFL_CNT, 255);
    L1A_MATCH = 1'b1;
    step();
    L1A_MATCH = 1'b0;
    repeat (3) step();
    do_reset();
    step();

    // randomized traffic, read rate varied per phase
    rnd = 1;
    for (int p = 0; p < 6; p++) begin
      repeat (500) begin
        L1A_MATCH = ($urandom_range(0, 7) == 0);
        NSAMP = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 127))
                                            : 7'($urandom_range(0, 12));
        RD_EN = ($urandom_range(0, 4) < p);
        FLUSH = ($urandom_range(0, 399) == 0);
        step();
      end
    end
    L1A_MATCH = 1'b0;
    FLUSH = 1'b0;
    RD_EN = 1'b1;
    repeat (300) step();
    RD_EN = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
